// File: rtl/cpu_monitor_pkg.sv
// Shared definitions for the CPU monitor: view-select codes, counter slots and
// the hex-to-7-segment glyph table.
package cpu_monitor_pkg;

   localparam int unsigned DataW  = 32;
   localparam int unsigned SelW   = 3;
   localparam int unsigned NumCnt = 7;
   localparam int unsigned NumDig = 8;

   localparam logic [SelW-1:0] MonSelDisplay  = 3'd0;
   localparam logic [SelW-1:0] MonSelCycles   = 3'd1;
   localparam logic [SelW-1:0] MonSelJumps    = 3'd2;
   localparam logic [SelW-1:0] MonSelBranches = 3'd3;
   localparam logic [SelW-1:0] MonSelTaken    = 3'd4;
   localparam logic [SelW-1:0] MonSelNops     = 3'd5;
   localparam logic [SelW-1:0] MonSelDbpHit   = 3'd6;
   localparam logic [SelW-1:0] MonSelDbpMiss  = 3'd7;

   // Counter slots; slot n is viewed with sel = n + 1
   localparam int unsigned CntCycles   = 0;
   localparam int unsigned CntJumps    = 1;
   localparam int unsigned CntBranches = 2;
   localparam int unsigned CntTaken    = 3;
   localparam int unsigned CntNops     = 4;
   localparam int unsigned CntDbpHit   = 5;
   localparam int unsigned CntDbpMiss  = 6;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] Glyph0 = 7'h40;
   localparam logic [6:0] Glyph1 = 7'h79;
   localparam logic [6:0] Glyph2 = 7'h24;
   localparam logic [6:0] Glyph3 = 7'h30;
   localparam logic [6:0] Glyph4 = 7'h19;
   localparam logic [6:0] Glyph5 = 7'h12;
   localparam logic [6:0] Glyph6 = 7'h02;
   localparam logic [6:0] Glyph7 = 7'h78;
   localparam logic [6:0] Glyph8 = 7'h00;
   localparam logic [6:0] Glyph9 = 7'h10;
   localparam logic [6:0] GlyphA = 7'h08;
   localparam logic [6:0] GlyphB = 7'h03;
   localparam logic [6:0] GlyphC = 7'h46;
   localparam logic [6:0] GlyphD = 7'h21;
   localparam logic [6:0] GlyphE = 7'h06;
   localparam logic [6:0] GlyphF = 7'h0E;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = Glyph0;
         4'h1:    g = Glyph1;
         4'h2:    g = Glyph2;
         4'h3:    g = Glyph3;
         4'h4:    g = Glyph4;
         4'h5:    g = Glyph5;
         4'h6:    g = Glyph6;
         4'h7:    g = Glyph7;
         4'h8:    g = Glyph8;
         4'h9:    g = Glyph9;
         4'hA:    g = GlyphA;
         4'hB:    g = GlyphB;
         4'hC:    g = GlyphC;
         4'hD:    g = GlyphD;
         4'hE:    g = GlyphE;
         default: g = GlyphF;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/cpu_monitor_seg_scan.sv
// Free-running 8-digit multiplexer: lights one digit per ScanDiv cycles and
// registers the active-low anode and cathode drives for it.
module seg_scan
   import cpu_monitor_pkg::*;
#(
   parameter int unsigned ScanDiv = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat
);

   localparam int unsigned PreW = (ScanDiv > 2) ? $clog2(ScanDiv) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(ScanDiv - 1);

   logic [PreW-1:0] pre;
   logic [2:0]      idx;
   logic            wrap_c;
   logic [7:0]      an_c;
   logic [7:0]      cat_c;

   assign wrap_c = (pre == PreLast);

   // Drives for the digit currently selected by idx
   always_comb begin
      an_c  = ~(8'b1 << idx);
      cat_c = {~dp_mask[idx], hex_glyph(data[{idx, 2'b00} +: 4])};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre     <= '0;
         idx     <= '0;
         seg_an  <= 8'hFF;
         seg_cat <= 8'hFF;
      end else begin
         pre     <= wrap_c ? '0 : pre + 1'b1;
         idx     <= wrap_c ? idx + 3'd1 : idx;
         seg_an  <= an_c;
         seg_cat <= cat_c;
      end
   end

endmodule

// File: rtl/cpu_monitor.sv
// Pipeline event counters with sticky halt, a registered view mux and a
// 7-segment display of the selected word.
module cpu_monitor
   import cpu_monitor_pkg::*;
#(
   parameter int unsigned ScanDiv = 100000,
   parameter int unsigned CntBits = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        clr,
   input  logic        is_jump,
   input  logic        is_branch,
   input  logic        branched,
   input  logic        is_nop,
   input  logic        dbp_hit,
   input  logic        dbp_miss,
   input  logic        halt,
   input  logic [31:0] display,
   input  logic [2:0]  sel,
   output logic [31:0] view,
   output logic        halted,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat
);

   logic [CntBits-1:0] cnt [NumCnt];
   logic [NumCnt-1:0]  ev_c;
   logic               cq_c;
   logic [DataW-1:0]   view_c;

   assign cq_c = en & ~halted;
   assign ev_c = {dbp_miss, dbp_hit, is_nop, branched, is_branch, is_jump, 1'b1};

   // Event counters; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumCnt; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NumCnt; i++) begin
            if (clr)                cnt[i] <= '0;
            else if (cq_c && ev_c[i]) cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         halted <= 1'b0;
      else if (clr)       halted <= 1'b0;
      else if (en && halt) halted <= 1'b1;
   end

   always_comb begin
      view_c = display;
      case (sel)
         MonSelCycles:   view_c = DataW'(cnt[CntCycles]);
         MonSelJumps:    view_c = DataW'(cnt[CntJumps]);
         MonSelBranches: view_c = DataW'(cnt[CntBranches]);
         MonSelTaken:    view_c = DataW'(cnt[CntTaken]);
         MonSelNops:     view_c = DataW'(cnt[CntNops]);
         MonSelDbpHit:   view_c = DataW'(cnt[CntDbpHit]);
         MonSelDbpMiss:  view_c = DataW'(cnt[CntDbpMiss]);
         default:        view_c = display;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) view <= '0;
      else        view <= view_c;
   end

   // Decimal point on digit 0 flags a halted core
   seg_scan #(
      .ScanDiv (ScanDiv)
   ) u_seg_scan (
      .clk     (clk),
      .rst_n   (rst_n),
      .data    (view),
      .dp_mask (8'(halted)),
      .seg_an  (seg_an),
      .seg_cat (seg_cat)
   );

endmodule

// File: tb/tb_cpu_monitor.sv
// Randomised and directed bench for cpu_monitor against an edge-count based
// behavioural model, with literal checks that pin the model.
module tb_cpu_monitor;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned CNT_BITS = 4;
   localparam int unsigned MOD      = 1 << CNT_BITS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, clr = 1'b0, halt = 1'b0;
   logic        is_jump = 1'b0, is_branch = 1'b0, branched = 1'b0;
   logic        is_nop = 1'b0, dbp_hit = 1'b0, dbp_miss = 1'b0;
   logic [31:0] display = 32'h0;
   logic [2:0]  sel = 3'd0;
   logic [31:0] view;
   logic        halted;
   logic [7:0]  seg_an, seg_cat;

   cpu_monitor #(.ScanDiv(SCAN_DIV), .CntBits(CNT_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .is_jump(is_jump), .is_branch(is_branch), .branched(branched),
      .is_nop(is_nop), .dbp_hit(dbp_hit), .dbp_miss(dbp_miss),
      .halt(halt), .display(display), .sel(sel),
      .view(view), .halted(halted), .seg_an(seg_an), .seg_cat(seg_cat)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: counts as integers mod 2^CNT_BITS, digit index from edges since reset
   int unsigned m_cnt [7];
   logic        m_halted;
   logic [31:0] m_view;
   logic [7:0]  m_an, m_cat;
   int unsigned m_k, m_d;
   bit          m_cq;
   bit          m_ev [7];
   logic [31:0] m_sel_val;
   logic [3:0]  m_nib;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 7; i++) m_cnt[i] = 0;
         m_halted = 1'b0;
         m_view   = 32'h0;
         m_an     = 8'hFF;
         m_cat    = 8'hFF;
         m_k      = 0;
      end else begin
         m_d   = (m_k / SCAN_DIV) % 8;
         m_nib = 4'((m_view >> (4 * m_d)) & 32'hF);
         m_an  = ~(8'h01 << m_d);
         m_cat = {~(m_halted && m_d == 0), glyph_tab[m_nib]};
         m_k++;
         m_sel_val = (sel == 3'd0) ? display : 32'(m_cnt[int'(sel) - 1]);
         m_cq  = en && !m_halted;
         m_ev  = '{1'b1, is_jump, is_branch, branched, is_nop, dbp_hit, dbp_miss};
         for (int i = 0; i < 7; i++) begin
            if (clr)                 m_cnt[i] = 0;
            else if (m_cq && m_ev[i]) m_cnt[i] = (m_cnt[i] + 1) % MOD;
         end
         m_halted = clr ? 1'b0 : (m_halted || (en && halt));
         m_view   = m_sel_val;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("view",    view,           m_view);
         check("halted",  32'(halted),    32'(m_halted));
         check("seg_an",  32'(seg_an),    32'(m_an));
         check("seg_cat", 32'(seg_cat),   32'(m_cat));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobes_off();
      is_jump = 0; is_branch = 0; branched = 0; is_nop = 0; dbp_hit = 0; dbp_miss = 0;
      halt = 0;
   endtask

   logic [6:0] frame_glyph [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
   logic [7:0] prev_an;
   logic [7:0] an_exp;
   bit         found;
   int         dp_lit, dp_wrong;

   initial begin
      en = 1; sel = 3'd1;
      tick(3);
      chk_on = 1'b1;
      check("reset_seg_an", 32'(seg_an), 32'hFF);
      check("reset_seg_cat", 32'(seg_cat), 32'hFF);
      check("reset_view", view, 32'h0);
      rst_n = 1'b1;

      // Ten enabled cycles with no strobes
      tick(1);
      check("first_an", 32'(seg_an), 32'hFE);
      tick(9);
      check("cycles_view9", view, 32'd9);
      en = 0;
      tick(2);
      check("cycles_view10", view, 32'd10);

      // Taken branches with one stalled cycle
      clr = 1; tick(1); clr = 0;
      sel = 3'd4; branched = 1; en = 1; tick(2);
      en = 0; tick(1);
      en = 1; tick(2);
      branched = 0; en = 0; tick(2);
      check("taken4", view, 32'd4);

      // Halt with a same-cycle jump, later jumps ignored
      clr = 1; tick(1); clr = 0;
      sel = 3'd2; en = 1; is_jump = 1; halt = 1; tick(1);
      halt = 0; tick(3);
      is_jump = 0; tick(2);
      check("jumps1", view, 32'd1);
      check("halted1", 32'(halted), 32'd1);
      dp_lit = 0; dp_wrong = 0;
      for (int j = 0; j < 8 * SCAN_DIV; j++) begin
         tick(1);
         if (!seg_cat[7]) begin
            dp_lit++;
            if (seg_an != 8'hFE) dp_wrong++;
         end
      end
      check("dp_lit_cycles", 32'(dp_lit), 32'(SCAN_DIV));
      check("dp_off_digit0", 32'(dp_wrong), 32'd0);
      clr = 1; is_jump = 1; tick(1);
      clr = 0; is_jump = 0; en = 0; tick(2);
      check("jumps_clr", view, 32'd0);
      check("halted_clr", 32'(halted), 32'd0);

      // Counter wrap at 2^CNT_BITS
      clr = 1; tick(1); clr = 0;
      sel = 3'd5; en = 1; is_nop = 1; tick(17);
      is_nop = 0; en = 0; tick(2);
      check("nop_wrap", view, 32'h1);

      // Display scan order over a full frame
      sel = 3'd0; display = 32'h89ABCDEF; tick(2);
      found = 1'b0;
      for (int j = 0; j < 64 && !found; j++) begin
         prev_an = seg_an;
         tick(1);
         if (prev_an == 8'h7F && seg_an == 8'hFE) found = 1'b1;
      end
      check("frame_start_found", 32'(found), 32'd1);
      for (int j = 0; j < 8 * SCAN_DIV; j++) begin
         an_exp = ~(8'h01 << (j / SCAN_DIV));
         check("scan_an", 32'(seg_an), 32'(an_exp));
         check("scan_glyph", 32'(seg_cat[6:0]), 32'(frame_glyph[j / SCAN_DIV]));
         tick(1);
      end
      check("scan_wrap", 32'(seg_an), 32'hFE);

      // Random traffic
      for (int j = 0; j < 600; j++) begin
         en        = ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 40) == 0);
         halt      = ($urandom_range(0, 50) == 0);
         is_jump   = $urandom_range(0, 1) == 1;
         is_branch = $urandom_range(0, 1) == 1;
         branched  = $urandom_range(0, 1) == 1;
         is_nop    = $urandom_range(0, 1) == 1;
         dbp_hit   = $urandom_range(0, 1) == 1;
         dbp_miss  = $urandom_range(0, 1) == 1;
         sel       = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) display = $urandom;
         tick(1);
      end

      // Asynchronous reset mid-count
      strobes_off(); clr = 1; tick(1); clr = 0;
      sel = 3'd1; en = 1; tick(5);
      #2 rst_n = 1'b0;
      #1;
      check("async_view", view, 32'h0);
      check("async_an", 32'(seg_an), 32'hFF);
      check("async_cat", 32'(seg_cat), 32'hFF);
      check("async_halted", 32'(halted), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("restart_view", view, 32'd2);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
